// File: rtl/ddr3_rdcal_pkg.sv
// Shared types and constants for the DDR3 read-leveling / read-data stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ddr3_rdcal_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_REQ,
        ST_WAIT,
        ST_NEXT,
        ST_DONE,
        ST_FAIL
    } state_t;

    localparam int         BURST_BEATS = 4;
    localparam logic       MPR_Q0      = 1'b0;
    localparam logic       MPR_Q1      = 1'b1;
    localparam logic [1:0] SHIFT_MAX   = 2'd3;

    // Lowest set bit of the pass mask; the mask is known non-zero when used.
    function automatic logic [1:0] lowest_pass(input logic [3:0] mask);
        logic [1:0] sel;
        sel = 2'd3;
        if (mask[2]) sel = 2'd2;
        if (mask[1]) sel = 2'd1;
        if (mask[0]) sel = 2'd0;
        return sel;
    endfunction

endpackage

// File: rtl/ddr3_rd_calib_if.sv
// MPR handshake, IOB capture and aligned read-data bundle for ddr3_rd_calib.
// Latency: n/a (signal bundle only).
// Backpressure: none; read data is a push-only stream, MPR reads use req/ack.
interface ddr3_rd_calib_if #(
    parameter int WIDTH = 16
) ();
    logic                   mpr_req_o;
    logic                   mpr_ack_i;
    logic [WIDTH-1:0]       iob_q0_i;
    logic [WIDTH-1:0]       iob_q1_i;
    logic                   rd_cmd_i;
    logic                   rd_valid_o;
    logic                   rd_last_o;
    logic [2*WIDTH-1:0]     rd_data_o;

    // Controller / IOB side
    modport master (
        input  mpr_req_o, rd_valid_o, rd_last_o, rd_data_o,
        output mpr_ack_i, iob_q0_i, iob_q1_i, rd_cmd_i
    );

    // Calibration stage side
    modport slave (
        output mpr_req_o, rd_valid_o, rd_last_o, rd_data_o,
        input  mpr_ack_i, iob_q0_i, iob_q1_i, rd_cmd_i
    );
endinterface

// File: rtl/ddr3_rdcal_dly.sv
// Tapped pulse delay line turning read-command pulses into a 4-beat valid/last window.
// Latency: window opens lag+1 cycles after the command (registered outputs).
// Backpressure: none; commands always shift in, en only masks the outputs.
module ddr3_rdcal_dly
    import ddr3_rdcal_pkg::*;
#(
    parameter int DEPTH = 14,
    parameter int LAGW  = 4
) (
    input  logic            clk_x1,
    input  logic            reset,
    input  logic            cmd,
    input  logic            en,
    input  logic [LAGW-1:0] lag,
    output logic            valid,
    output logic            last
);
    logic [DEPTH-1:1] sr_q;
    logic [DEPTH-1:0] taps;
    logic             win_c;
    logic             last_c;

    assign taps = {sr_q, cmd};

    // Shift every cycle regardless of calibration state.
    always_ff @(posedge clk_x1) begin
        if (reset) sr_q <= '0;
        else       sr_q <= taps[DEPTH-2:0];
    end

    // Select the lag..lag+3 window and its final tap.
    always_comb begin
        win_c  = 1'b0;
        last_c = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i >= int'(lag) && i <= int'(lag) + BURST_BEATS - 1)
                win_c = win_c | taps[i];
            if (i == int'(lag) + BURST_BEATS - 1)
                last_c = taps[i];
        end
    end

    // Register the window so it lines up with the registered read data.
    always_ff @(posedge clk_x1) begin
        if (reset) begin
            valid <= 1'b0;
            last  <= 1'b0;
        end else begin
            valid <= en & win_c;
            last  <= en & last_c;
        end
    end
endmodule

// File: rtl/ddr3_rd_calib.sv
// DDR3 read leveling (SHIFT 0..3 sweep over MPR reads) and aligned 4-beat read-data path.
// Latency: read data valid rd_cmd_i + lag_o + 1 cycles; MPR reads wait for mpr_ack_i.
// Backpressure: MPR req held until ack; read stream is push-only. Option: DDR3_RDCAL_VOTE_EN.
module ddr3_rd_calib
    import ddr3_rdcal_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int RDLAT  = 6,
    parameter int MAXDLY = 4,
    parameter int SETTLE = 4,
    localparam int LAGW  = $clog2(RDLAT + MAXDLY + 1)
) (
    input  logic             clk_x1,
    input  logic             reset,
    input  logic             start_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             fail_o,
    output logic [1:0]       shift_o,
    output logic [LAGW-1:0]  lag_o,
    ddr3_rd_calib_if.slave   bus
);
    localparam int CNTN = (RDLAT + MAXDLY + 5 > SETTLE + 1) ? RDLAT + MAXDLY + 5 : SETTLE + 1;
    localparam int CNTW = $clog2(CNTN);
    localparam logic [CNTW-1:0] RDLAT_C  = CNTW'(RDLAT);
    localparam logic [CNTW-1:0] TMO_C    = CNTW'(RDLAT + MAXDLY + 3);
    localparam logic [CNTW-1:0] SETTLE_C = CNTW'(SETTLE - 1);

    state_t            state_q, state_d;
    logic [1:0]        shift_q;
    logic [LAGW-1:0]   lag_q;
    logic [3:0]        pass_q;
    logic [LAGW-1:0]   lags_q [4];
    logic [CNTW-1:0]   cnt_q;
    logic [2:0]        run_q;
    logic [2*WIDTH-1:0] data_q;

    logic [CNTW-1:0]   idx;
    logic              match, timeout, hit, rec_pass, last_read;
    logic [2:0]        run_d;
    logic [LAGW-1:0]   hit_lag;

`ifdef DDR3_RDCAL_VOTE_EN
    logic              rd_idx_q, v_ok_q;
    logic [LAGW-1:0]   v_lag_q;
    assign last_read = rd_idx_q;
`else
    assign last_read = 1'b1;
`endif

    // Beat index, pattern match and run tracking for the current MPR burst.
    always_comb begin
        idx      = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        match    = (bus.iob_q0_i == {WIDTH{MPR_Q0}}) && (bus.iob_q1_i == {WIDTH{MPR_Q1}});
        run_d    = (match && idx >= RDLAT_C) ? run_q + 3'd1 : 3'd0;
        timeout  = idx > TMO_C;
        hit      = (run_d == 3'(BURST_BEATS)) && !timeout;
        hit_lag  = LAGW'(idx - CNTW'(BURST_BEATS - 1));
`ifdef DDR3_RDCAL_VOTE_EN
        rec_pass = hit && rd_idx_q && v_ok_q && (v_lag_q == hit_lag);
`else
        rec_pass = hit;
`endif
    end

    // State register.
    always_ff @(posedge clk_x1) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        state_d       = state_q;
        busy_o        = 1'b1;
        done_o        = 1'b0;
        fail_o        = 1'b0;
        bus.mpr_req_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy_o = 1'b0;
                if (start_i) state_d = ST_SETTLE;
            end
            ST_SETTLE: if (cnt_q == SETTLE_C) state_d = ST_REQ;
            ST_REQ: begin
                bus.mpr_req_o = 1'b1;
                if (bus.mpr_ack_i) state_d = ST_WAIT;
            end
            ST_WAIT: if (hit || timeout) state_d = ST_NEXT;
            ST_NEXT: begin
                if (!last_read)                 state_d = ST_REQ;
                else if (shift_q != SHIFT_MAX)  state_d = ST_SETTLE;
                else if (pass_q != 4'd0)        state_d = ST_DONE;
                else                            state_d = ST_FAIL;
            end
            ST_DONE: begin
                busy_o = 1'b0;
                done_o = 1'b1;
                if (start_i) state_d = ST_SETTLE;
            end
            ST_FAIL: begin
                busy_o = 1'b0;
                fail_o = 1'b1;
                if (start_i) state_d = ST_SETTLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sweep datapath: shift, counters, pass mask, per-shift lag and locked result.
    always_ff @(posedge clk_x1) begin
        if (reset) begin
            shift_q <= 2'd0;
            lag_q   <= '0;
            pass_q  <= 4'd0;
            cnt_q   <= '0;
            run_q   <= 3'd0;
            for (int i = 0; i < 4; i++) lags_q[i] <= '0;
`ifdef DDR3_RDCAL_VOTE_EN
            rd_idx_q <= 1'b0;
            v_ok_q   <= 1'b0;
            v_lag_q  <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE, ST_FAIL: begin
                    if (start_i) begin
                        shift_q <= 2'd0;
                        lag_q   <= '0;
                        pass_q  <= 4'd0;
                        cnt_q   <= '0;
`ifdef DDR3_RDCAL_VOTE_EN
                        rd_idx_q <= 1'b0;
`endif
                    end
                end
                ST_SETTLE: cnt_q <= cnt_q + 1'b1;
                ST_REQ: begin
                    if (bus.mpr_ack_i) begin
                        cnt_q <= '0;
                        run_q <= 3'd0;
                    end
                end
                ST_WAIT: begin
                    cnt_q <= idx;
                    run_q <= run_d;
                    if (rec_pass) begin
                        pass_q[shift_q] <= 1'b1;
                        lags_q[shift_q] <= hit_lag;
                    end
`ifdef DDR3_RDCAL_VOTE_EN
                    // First read of a shift only arms the vote.
                    if (!rd_idx_q && (hit || timeout)) begin
                        v_ok_q  <= hit;
                        v_lag_q <= hit_lag;
                    end
`endif
                end
                ST_NEXT: begin
                    cnt_q <= '0;
`ifdef DDR3_RDCAL_VOTE_EN
                    rd_idx_q <= ~rd_idx_q;
`endif
                    if (last_read) begin
                        if (shift_q != SHIFT_MAX) begin
                            shift_q <= shift_q + 2'd1;
                        end else if (pass_q != 4'd0) begin
                            shift_q <= lowest_pass(pass_q);
                            lag_q   <= lags_q[lowest_pass(pass_q)];
                        end else begin
                            shift_q <= 2'd0;
                            lag_q   <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Capture both half-beats every cycle; valid marks which ones matter.
    always_ff @(posedge clk_x1) begin
        if (reset) data_q <= '0;
        else       data_q <= {bus.iob_q1_i, bus.iob_q0_i};
    end

    assign shift_o       = shift_q;
    assign lag_o         = lag_q;
    assign bus.rd_data_o = data_q;

    ddr3_rdcal_dly #(
        .DEPTH (RDLAT + MAXDLY + 4),
        .LAGW  (LAGW)
    ) u_dly (
        .clk_x1 (clk_x1),
        .reset  (reset),
        .cmd    (bus.rd_cmd_i),
        .en     (done_o),
        .lag    (lag_q),
        .valid  (bus.rd_valid_o),
        .last   (bus.rd_last_o)
    );
endmodule
